// File: rtl/class_select_if.sv
`default_nettype none
// ============================================================================
// Module   : class_select_if
// Brief    : Score-stream input and classification-result handshake bundle
//            for class_select. The slave modport is the classifier's view;
//            the master modport is the producer/host view.
// Revision : 1.0 - initial release
// ============================================================================
interface class_select_if #(
    parameter int DATA_WIDTH_OUT = 32,
    parameter int IDX_WIDTH      = 6,
    parameter int CNT_WIDTH      = 16
);
    // score stream from the network top
    logic                      in_valid;
    logic [DATA_WIDTH_OUT-1:0] in_data;
    logic                      in_end;
    // result handshake towards the host
    logic                      res_ready;
    logic                      res_valid;
    logic [IDX_WIDTH-1:0]      res_class;
    logic [DATA_WIDTH_OUT-1:0] res_score;
    logic [IDX_WIDTH-1:0]      res_second;
    logic [DATA_WIDTH_OUT-1:0] res_margin;
    logic                      res_short;
    logic                      res_overrun;
    logic [CNT_WIDTH-1:0]      frame_cnt;

    modport master (
        output in_valid, in_data, in_end, res_ready,
        input  res_valid, res_class, res_score, res_second,
               res_margin, res_short, res_overrun, frame_cnt
    );

    modport slave (
        input  in_valid, in_data, in_end, res_ready,
        output res_valid, res_class, res_score, res_second,
               res_margin, res_short, res_overrun, frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/class_select.sv
`default_nettype none
// ============================================================================
// Module   : class_select
// Brief    : Top-1 / top-2 tracker over a per-frame softmax score stream.
//            Accumulators and result registers are separate, so the next
//            frame streams in while the last result awaits acknowledgement.
// Revision : 1.0 - initial release
// ============================================================================
module class_select #(
    parameter int DATA_WIDTH_OUT = 32,
    parameter int NUM_CLASS      = 40,
    parameter int IDX_WIDTH      = 6,
    parameter int CNT_WIDTH      = 16
) (
    input  logic          clk1,
    input  logic          rst_n,
    class_select_if.slave bus
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASS - 1);

    // frame accumulators
    logic [IDX_WIDTH-1:0]      idx_q,        idx_d;
    logic [IDX_WIDTH-1:0]      best_idx_q,   best_idx_d;
    logic [DATA_WIDTH_OUT-1:0] best_score_q, best_score_d;
    logic [IDX_WIDTH-1:0]      sec_idx_q,    sec_idx_d;
    logic [DATA_WIDTH_OUT-1:0] sec_score_q,  sec_score_d;

    // published result
    state_t                    state_q;
    logic [IDX_WIDTH-1:0]      res_class_q;
    logic [DATA_WIDTH_OUT-1:0] res_score_q;
    logic [IDX_WIDTH-1:0]      res_second_q;
    logic [DATA_WIDTH_OUT-1:0] res_margin_q;
    logic                      res_short_q;
    logic                      res_overrun_q;
    logic [CNT_WIDTH-1:0]      frame_cnt_q;

    logic is_last;
    logic short_close;
    logic frame_close;

    // A sample riding with in_end counts, so even idx==0 plus in_valid closes
    // a one-sample short frame; a bare in_end at idx==0 has nothing to close.
    assign is_last     = bus.in_valid && (idx_q == LAST_IDX);
    assign short_close = bus.in_end && !is_last && (bus.in_valid || (idx_q != '0));
    assign frame_close = is_last || short_close;

    // Fold the current sample into the running top-2 (strict compare: ties keep lower index)
    always_comb begin
        idx_d        = idx_q;
        best_idx_d   = best_idx_q;
        best_score_d = best_score_q;
        sec_idx_d    = sec_idx_q;
        sec_score_d  = sec_score_q;
        if (bus.in_valid) begin
            if (idx_q == '0) begin
                best_idx_d   = '0;
                best_score_d = bus.in_data;
                sec_idx_d    = '0;
                sec_score_d  = '0;
            end else if (bus.in_data > best_score_q) begin
                sec_idx_d    = best_idx_q;
                sec_score_d  = best_score_q;
                best_idx_d   = idx_q;
                best_score_d = bus.in_data;
            end else if (bus.in_data > sec_score_q) begin
                sec_idx_d    = idx_q;
                sec_score_d  = bus.in_data;
            end
            idx_d = idx_q + IDX_WIDTH'(1);
        end
        if (frame_close) begin
            idx_d = '0;
        end
    end

    // Accumulator registers; reset discards any partial frame
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            idx_q        <= '0;
            best_idx_q   <= '0;
            best_score_q <= '0;
            sec_idx_q    <= '0;
            sec_score_q  <= '0;
        end else begin
            idx_q        <= idx_d;
            best_idx_q   <= best_idx_d;
            best_score_q <= best_score_d;
            sec_idx_q    <= sec_idx_d;
            sec_score_q  <= sec_score_d;
        end
    end

    // Result handshake FSM: a close always publishes; an unacknowledged overwrite is sticky
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q       <= EMPTY;
            res_class_q   <= '0;
            res_score_q   <= '0;
            res_second_q  <= '0;
            res_margin_q  <= '0;
            res_short_q   <= 1'b0;
            res_overrun_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else if (frame_close) begin
            state_q      <= FULL;
            res_class_q  <= best_idx_d;
            res_score_q  <= best_score_d;
            res_second_q <= sec_idx_d;
            res_margin_q <= best_score_d - sec_score_d;
            res_short_q  <= short_close;
            frame_cnt_q  <= frame_cnt_q + CNT_WIDTH'(1);
            if ((state_q == FULL) && !bus.res_ready) begin
                res_overrun_q <= 1'b1;
            end
        end else if ((state_q == FULL) && bus.res_ready) begin
            state_q <= EMPTY;
        end
    end

    assign bus.res_valid   = (state_q == FULL);
    assign bus.res_class   = res_class_q;
    assign bus.res_score   = res_score_q;
    assign bus.res_second  = res_second_q;
    assign bus.res_margin  = res_margin_q;
    assign bus.res_short   = res_short_q;
    assign bus.res_overrun = res_overrun_q;
    assign bus.frame_cnt   = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_class_select.sv
`default_nettype none
// ============================================================================
// Module   : tb_class_select
// Brief    : Directed, table-driven bench for class_select with hand-written
//            sequences for overrun, simultaneous events and mid-frame reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_class_select;

    localparam int DW = 32;
    localparam int NC = 40;
    localparam int IW = 6;
    localparam int CW = 16;

    logic clk1  = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk1 = ~clk1;

    class_select_if #(.DATA_WIDTH_OUT(DW), .IDX_WIDTH(IW), .CNT_WIDTH(CW)) bus ();

    class_select #(
        .DATA_WIDTH_OUT(DW),
        .NUM_CLASS     (NC),
        .IDX_WIDTH     (IW),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk1 (clk1),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int          pat;
        int          len;
        bit          end_last;
        int          e_class;
        logic [31:0] e_score;
        int          e_second;
        logic [31:0] e_margin;
        bit          e_short;
    } vec_t;

    vec_t tbl [10];
    int   n_vec   = 0;
    int   n_bad   = 0;
    int   exp_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Score patterns, one value per class index
    function automatic logic [31:0] sample_val(input int pat, input int i);
        logic [31:0] v;
        case (pat)
            0:       v = (i == 17) ? 32'd5000 : ((i == 3) ? 32'd4000 : 32'(100 + i));
            1:       v = ((i == 5) || (i == 9)) ? 32'd777 : 32'd1;
            3:       v = 32'(1000 - i);
            4:       v = 32'(i * 3);
            5:       v = 32'd0;
            6:       v = (i == 20) ? 32'hFFFF_FFFF : (32'h8000_0000 + 32'(i));
            7:       v = 32'd55;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    task automatic send_frame(input int pat, input int len, input bit end_last, input bit ready_last);
        for (int i = 0; i < len; i++) begin
            @(negedge clk1);
            bus.in_valid  = 1'b1;
            bus.in_data   = sample_val(pat, i);
            bus.in_end    = end_last && (i == len - 1);
            bus.res_ready = ready_last && (i == len - 1);
        end
        @(negedge clk1);
        bus.in_valid  = 1'b0;
        bus.in_end    = 1'b0;
        bus.res_ready = 1'b0;
        bus.in_data   = '0;
    endtask

    task automatic check_result(input string tag, input int c, input logic [31:0] s,
                                input int sec, input logic [31:0] m, input bit sh);
        check({tag, ".valid"},  64'(bus.res_valid),  64'd1);
        check({tag, ".class"},  64'(bus.res_class),  64'(c));
        check({tag, ".score"},  64'(bus.res_score),  64'(s));
        check({tag, ".second"}, 64'(bus.res_second), 64'(sec));
        check({tag, ".margin"}, 64'(bus.res_margin), 64'(m));
        check({tag, ".short"},  64'(bus.res_short),  64'(sh));
        check({tag, ".fcnt"},   64'(bus.frame_cnt),  64'(exp_cnt));
    endtask

    task automatic ack(input string tag);
        @(negedge clk1);
        bus.res_ready = 1'b1;
        @(negedge clk1);
        bus.res_ready = 1'b0;
        check({tag, ".valid_after_ack"}, 64'(bus.res_valid), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".valid"},   64'(bus.res_valid),   64'd0);
        check({tag, ".class"},   64'(bus.res_class),   64'd0);
        check({tag, ".score"},   64'(bus.res_score),   64'd0);
        check({tag, ".second"},  64'(bus.res_second),  64'd0);
        check({tag, ".margin"},  64'(bus.res_margin),  64'd0);
        check({tag, ".short"},   64'(bus.res_short),   64'd0);
        check({tag, ".overrun"}, 64'(bus.res_overrun), 64'd0);
        check({tag, ".fcnt"},    64'(bus.frame_cnt),   64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        // pat, len, end_last, class, score, second, margin, short
        tbl[0] = '{0, 40, 1'b0, 17, 32'd5000,      3,  32'd1000,      1'b0};
        tbl[1] = '{1, 40, 1'b0, 5,  32'd777,       9,  32'd0,         1'b0};
        tbl[2] = '{0, 12, 1'b1, 3,  32'd4000,      11, 32'd3889,      1'b1};
        tbl[3] = '{0, 40, 1'b0, 17, 32'd5000,      3,  32'd1000,      1'b0};
        tbl[4] = '{3, 40, 1'b0, 0,  32'd1000,      1,  32'd1,         1'b0};
        tbl[5] = '{4, 40, 1'b0, 39, 32'd117,       38, 32'd3,         1'b0};
        tbl[6] = '{5, 40, 1'b0, 0,  32'd0,         0,  32'd0,         1'b0};
        tbl[7] = '{6, 40, 1'b0, 20, 32'hFFFF_FFFF, 39, 32'h7FFF_FFD8, 1'b0};
        tbl[8] = '{7, 1,  1'b1, 0,  32'd55,        0,  32'd55,        1'b1};
        tbl[9] = '{1, 40, 1'b1, 5,  32'd777,       9,  32'd0,         1'b0};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_end    = 1'b0;
        bus.res_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk1);
        check_all_zero("reset");
        rst_n = 1'b1;

        // table-driven frames, each acknowledged before the next
        for (int v = 0; v < 10; v++) begin
            send_frame(tbl[v].pat, tbl[v].len, tbl[v].end_last, 1'b0);
            exp_cnt++;
            check_result($sformatf("vec%0d", v), tbl[v].e_class, tbl[v].e_score,
                         tbl[v].e_second, tbl[v].e_margin, tbl[v].e_short);
            check($sformatf("vec%0d.overrun", v), 64'(bus.res_overrun), 64'd0);
            ack($sformatf("vec%0d", v));
            check($sformatf("vec%0d.hold_class", v), 64'(bus.res_class), 64'(tbl[v].e_class));
        end

        // res_ready coincident with a close while FULL: overwrite, no overrun
        send_frame(3, 40, 1'b0, 1'b0);
        exp_cnt++;
        check_result("simul_a", 0, 32'd1000, 1, 32'd1, 1'b0);
        send_frame(4, 40, 1'b0, 1'b1);
        exp_cnt++;
        check_result("simul_b", 39, 32'd117, 38, 32'd3, 1'b0);
        check("simul_b.overrun", 64'(bus.res_overrun), 64'd0);
        ack("simul_b");

        // bare in_end with idx==0 publishes nothing
        @(negedge clk1);
        bus.in_end = 1'b1;
        @(negedge clk1);
        bus.in_end = 1'b0;
        @(negedge clk1);
        check("end_idle.valid", 64'(bus.res_valid), 64'd0);
        check("end_idle.fcnt",  64'(bus.frame_cnt), 64'(exp_cnt));

        // bare in_end after 5 samples closes a short frame
        send_frame(4, 5, 1'b0, 1'b0);
        bus.in_end = 1'b1;
        @(negedge clk1);
        bus.in_end = 1'b0;
        exp_cnt++;
        check_result("end_short", 4, 32'd12, 3, 32'd3, 1'b1);
        ack("end_short");

        // two unacknowledged frames: overwrite and sticky overrun
        send_frame(0, 40, 1'b0, 1'b0);
        exp_cnt++;
        check_result("ovr_a", 17, 32'd5000, 3, 32'd1000, 1'b0);
        check("ovr_a.overrun", 64'(bus.res_overrun), 64'd0);
        send_frame(4, 40, 1'b0, 1'b0);
        exp_cnt++;
        check_result("ovr_b", 39, 32'd117, 38, 32'd3, 1'b0);
        check("ovr_b.overrun", 64'(bus.res_overrun), 64'd1);
        ack("ovr_b");
        check("ovr_b.overrun_sticky", 64'(bus.res_overrun), 64'd1);

        // reset mid-frame discards the partial frame and clears everything
        send_frame(1, 20, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk1);
        @(negedge clk1);
        check_all_zero("midrst");
        rst_n   = 1'b1;
        exp_cnt = 0;
        send_frame(1, 40, 1'b0, 1'b0);
        exp_cnt++;
        check_result("post_rst", 5, 32'd777, 9, 32'd0, 1'b0);
        check("post_rst.overrun", 64'(bus.res_overrun), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
